traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter GREEN_CYC, default 5000000, green duration in clock cycles, at least 1.
REQ-002 SHALL have parameter BLUE_CYC, default 2000000, blue (caution) duration in cycles, at least 1.
REQ-003 SHALL have parameter ALLRED_CYC, default 1000000, both-red clearance duration in cycles, at least 1.
REQ-004 SHALL have parameter WALK_CYC, default 5000000, pedestrian walk duration in cycles, at least 1.
REQ-005 SHALL have parameter FLASH_CYC, default 500000, night-mode half-period in cycles, at least 1.
REQ-006 SHALL have parameter CNT_W, default 32, phase counter width; every duration SHALL fit in CNT_W bits.
REQ-007 SHALL have port: clock, input, 1 bit, sole clock, rising edge.
REQ-008 SHALL have port: reset_n, input, 1 bit, synchronous active-low reset.
REQ-009 SHALL have port: ped_req, input, 1 bit, pedestrian request, level-sampled each cycle.
REQ-010 SHALL have port: night, input, 1 bit, night flashing-mode select.
REQ-011 SHALL have port: red, output, 2 bits, bit0 is road A, bit1 is road B.
REQ-012 SHALL have port: blue, output, 2 bits, caution lamps, same bit mapping as red.
REQ-013 SHALL have port: green, output, 2 bits, same bit mapping as red.
REQ-014 SHALL have port: walk, output, 1 bit, pedestrian walk lamp.
REQ-015 SHALL have port: ped_ack, output, 1 bit, one-cycle pulse when a request is served.
REQ-016 SHALL have port: phase, output, 3 bits, current state code.

Function
REQ-017 SHALL implement states with these codes: ALLRED0=0, A_GREEN=1, A_BLUE=2, ALLRED1=3, B_GREEN=4, B_BLUE=5, PED_WALK=6, NIGHT=7.
REQ-018 SHALL decode outputs from the registered state only (Moore), and phase SHALL equal the state code.
REQ-019 SHALL drive lamps per state: A_GREEN gives green=01, red=10; A_BLUE gives blue=01, red=10; B_GREEN gives green=10, red=01; B_BLUE gives blue=10, red=01; ALLRED0, ALLRED1 and PED_WALK give red=11; all other lamp bits are 0.
REQ-020 SHALL assert walk only in PED_WALK.
REQ-021 SHALL never assert green or blue on both roads in any non-NIGHT state, and SHALL never assert more than one lamp per road.
REQ-022 SHALL hold each timed state for exactly its duration in cycles: counter runs 0..DUR-1, state advances on the cycle after the counter equals DUR-1, and the counter returns to 0 on every state change.
REQ-023 SHALL sequence ALLRED0 -> A_GREEN -> A_BLUE -> ALLRED1 -> B_GREEN -> B_BLUE -> ALLRED0, with a PED_WALK insertion per REQ-025.
REQ-024 SHALL set pending flag ped_pend on any cycle with ped_req=1 outside PED_WALK; ped_req during PED_WALK SHALL be ignored.
REQ-025 SHALL, on ALLRED0 or ALLRED1 expiry with (ped_pend OR ped_req)=1, enter PED_WALK; on PED_WALK expiry, SHALL continue to the green that would have followed (A_GREEN after ALLRED0, B_GREEN after ALLRED1).
REQ-026 SHALL pulse ped_ack for exactly the first cycle of PED_WALK and SHALL clear ped_pend on entry.
REQ-027 SHALL, with night=1 on any cycle, enter NIGHT on the next cycle from any state with the counter cleared; ped_pend SHALL be retained.
REQ-028 SHALL in NIGHT drive red=00, green=00, walk=0 and blue=11/00, toggling every FLASH_CYC cycles and starting at 11.
REQ-029 SHALL, on the cycle night=0 is sampled in NIGHT, go to ALLRED0 with the counter at 0.
REQ-030 SHALL give night priority over timer expiry and the pedestrian insertion when they coincide.

Reset
REQ-031 SHALL, on a clock edge with reset_n=0, set state ALLRED0, counter 0, ped_pend 0 and flash phase 0, so outputs are red=11, blue=00, green=00, walk=0, ped_ack=0, phase=0.
REQ-032 SHALL let reset override night and ped_req, and reset mid-phase SHALL abort that phase with no partial pulse.

Verification (GREEN_CYC=5, BLUE_CYC=2, ALLRED_CYC=1, WALK_CYC=3, FLASH_CYC=2)
REQ-033 SHALL check: release reset, idle inputs -> phase 0,1x5,2x2,3,4x5,5x2,0, repeating with period 16.
REQ-034 SHALL check: ped_req pulse during A_GREEN -> after ALLRED1, PED_WALK for 3 cycles with walk=1 and ped_ack high in the first cycle only, then B_GREEN; next cycle has no walk.
REQ-035 SHALL check: ped_req held high continuously -> PED_WALK inserted after every all-red, cycle period 22, no ped_ack during PED_WALK re-latching.
REQ-036 SHALL check: night=1 mid B_GREEN -> next cycle phase=7, blue pattern 11,11,00,00,...; night=0 -> ALLRED0 then A_GREEN after 1 cycle.
REQ-037 SHALL check: reset_n=0 during PED_WALK with night=1 -> next edge gives phase=0, red=11, walk=0; pending request is lost.
REQ-038 SHALL check the invariant every cycle: no road has two lamps lit, and outside NIGHT green|blue is never 11.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road traffic light FSM with pedestrian walk insertion and night flashing mode.
module traffic_light_ctrl #(
    parameter int GREEN_CYC  = 5000000,
    parameter int BLUE_CYC   = 2000000,
    parameter int ALLRED_CYC = 1000000,
    parameter int WALK_CYC   = 5000000,
    parameter int FLASH_CYC  = 500000,
    parameter int CNT_W      = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ped_req,
    input  logic       night,
    output logic [1:0] red,
    output logic [1:0] blue,
    output logic [1:0] green,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    localparam logic [2:0] ALLRED0  = 3'd0;
    localparam logic [2:0] A_GREEN  = 3'd1;
    localparam logic [2:0] A_BLUE   = 3'd2;
    localparam logic [2:0] ALLRED1  = 3'd3;
    localparam logic [2:0] B_GREEN  = 3'd4;
    localparam logic [2:0] B_BLUE   = 3'd5;
    localparam logic [2:0] PED_WALK = 3'd6;
    localparam logic [2:0] NIGHT    = 3'd7;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] BLUE_LAST   = CNT_W'(BLUE_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, last;
    logic             ped_pend, ret_b, flash, expire, want_ped, enter_walk;

    always_comb begin
        last = (state == A_GREEN || state == B_GREEN) ? GREEN_LAST :
               (state == A_BLUE  || state == B_BLUE)  ? BLUE_LAST  :
               (state == PED_WALK)                    ? WALK_LAST  :
               (state == NIGHT)                       ? FLASH_LAST : ALLRED_LAST;
        expire   = cnt == last;
        want_ped = ped_pend | ped_req;
        state_nx = state;
        if (night)
            state_nx = NIGHT;
        else if (state == NIGHT)
            state_nx = ALLRED0;
        else if (expire)
            case (state)
                ALLRED0:  state_nx = want_ped ? PED_WALK : A_GREEN;
                A_GREEN:  state_nx = A_BLUE;
                A_BLUE:   state_nx = ALLRED1;
                ALLRED1:  state_nx = want_ped ? PED_WALK : B_GREEN;
                B_GREEN:  state_nx = B_BLUE;
                B_BLUE:   state_nx = ALLRED0;
                default:  state_nx = ret_b ? B_GREEN : A_GREEN;
            endcase
        enter_walk = state_nx == PED_WALK && state != PED_WALK;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ALLRED0;
            cnt      <= '0;
            ped_pend <= 1'b0;
            ret_b    <= 1'b0;
            flash    <= 1'b0;
        end else begin
            state    <= state_nx;
            // NIGHT never changes state while held, so its counter wraps on the flash period
            cnt      <= (state_nx != state || expire) ? '0 : cnt + 1'b1;
            flash    <= (state_nx != NIGHT) ? 1'b0 : (state == NIGHT && expire) ? ~flash : flash;
            ped_pend <= enter_walk ? 1'b0 : (ped_req && state != PED_WALK) ? 1'b1 : ped_pend;
            ret_b    <= enter_walk ? state == ALLRED1 : ret_b;
        end
    end

    always_comb begin
        red     = (state == ALLRED0 || state == ALLRED1 || state == PED_WALK) ? 2'b11 :
                  (state == A_GREEN || state == A_BLUE) ? 2'b10 :
                  (state == B_GREEN || state == B_BLUE) ? 2'b01 : 2'b00;
        green   = (state == A_GREEN) ? 2'b01 : (state == B_GREEN) ? 2'b10 : 2'b00;
        blue    = (state == A_BLUE) ? 2'b01 : (state == B_BLUE) ? 2'b10 :
                  (state == NIGHT) ? {2{~flash}} : 2'b00;
        walk    = state == PED_WALK;
        ped_ack = walk && cnt == '0;
        phase   = state;
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed scenario tests for traffic_light_ctrl with short phase durations.
module tb_traffic_light_ctrl;
    logic       clock = 1'b0, reset_n = 1'b0, ped_req = 1'b0, night = 1'b0;
    logic [1:0] red, blue, green;
    logic       walk, ped_ack;
    logic [2:0] phase;
    int         checks = 0, failures = 0;
    bit         inv_on = 1'b0;

    // lamp expectations per non-NIGHT phase code
    logic [1:0] red_t   [0:7] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00};
    logic [1:0] green_t [0:7] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] blue_t  [0:7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

    traffic_light_ctrl #(
        .GREEN_CYC(5), .BLUE_CYC(2), .ALLRED_CYC(1), .WALK_CYC(3), .FLASH_CYC(2), .CNT_W(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ped_req(ped_req), .night(night),
        .red(red), .blue(blue), .green(green), .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (inv_on) begin
            for (int r = 0; r < 2; r++) begin
                checks++;
                if (int'(red[r]) + int'(green[r]) + int'(blue[r]) > 1) begin
                    failures++;
                    $display("FAIL inv_one_lamp road=%0d red=%b green=%b blue=%b", r, red, green, blue);
                end
            end
            if (phase != 3'd7) begin
                checks++;
                if ((green | blue) === 2'b11) begin
                    failures++;
                    $display("FAIL inv_both_roads phase=%0d green=%b blue=%b", phase, green, blue);
                end
            end
        end
    end

    task automatic start(input bit pr);
        reset_n = 1'b0; ped_req = 1'b0; night = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1; ped_req = pr;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; night = 1'b1; ped_req = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({phase, red, blue, green, walk, ped_ack} !== {3'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset phase=%0d red=%b blue=%b green=%b walk=%b ack=%b want 0 11 00 00 0 0",
                     phase, red, blue, green, walk, ped_ack);
        end
        inv_on = 1'b1;
    endtask

    task automatic test_normal();
        int p16 [0:15] = '{0, 1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 4, 5, 5};
        int e;
        start(1'b0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clock);
            e = p16[k % 16];
            checks++;
            if ({phase, red, green, blue, walk, ped_ack} !== {3'(e), red_t[e], green_t[e], blue_t[e], 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL normal k=%0d phase=%0d red=%b green=%b blue=%b walk=%b ack=%b want phase=%0d",
                         k, phase, red, green, blue, walk, ped_ack, e);
            end
        end
    endtask

    task automatic test_ped_pulse();
        int pp [1:17] = '{1, 1, 1, 1, 1, 2, 2, 3, 6, 6, 6, 4, 4, 4, 4, 4, 5};
        int e;
        start(1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            e = pp[k];
            checks++;
            if ({phase, red, green, blue, walk, ped_ack} !==
                {3'(e), red_t[e], green_t[e], blue_t[e], e == 6, k == 9}) begin
                failures++;
                $display("FAIL ped_pulse k=%0d phase=%0d walk=%b ack=%b red=%b want phase=%0d walk=%b ack=%b",
                         k, phase, walk, ped_ack, red, e, e == 6, k == 9);
            end
            ped_req = (k == 2);
        end
    endtask

    task automatic test_ped_held();
        int p22 [0:21] = '{6, 6, 6, 1, 1, 1, 1, 1, 2, 2, 3, 6, 6, 6, 4, 4, 4, 4, 4, 5, 5, 0};
        int e, i;
        start(1'b1);
        for (int k = 1; k <= 44; k++) begin
            @(negedge clock);
            i = (k - 1) % 22;
            e = p22[i];
            checks++;
            if ({phase, walk, ped_ack} !== {3'(e), e == 6, i == 0 || i == 11}) begin
                failures++;
                $display("FAIL ped_held k=%0d phase=%0d walk=%b ack=%b want phase=%0d walk=%b ack=%b",
                         k, phase, walk, ped_ack, e, e == 6, i == 0 || i == 11);
            end
        end
        ped_req = 1'b0;
    endtask

    task automatic test_night();
        int pn [1:18] = '{1, 1, 1, 1, 1, 2, 2, 3, 4, 4, 7, 7, 7, 7, 7, 7, 0, 1};
        int e;
        logic [1:0] eb;
        start(1'b0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clock);
            e = pn[k];
            eb = (e == 7) ? ((((k - 11) / 2) % 2 == 0) ? 2'b11 : 2'b00) : blue_t[e];
            checks++;
            if ({phase, red, green, blue, walk} !== {3'(e), red_t[e], green_t[e], eb, 1'b0}) begin
                failures++;
                $display("FAIL night k=%0d phase=%0d red=%b green=%b blue=%b walk=%b want phase=%0d blue=%b",
                         k, phase, red, green, blue, walk, e, eb);
            end
            night = (k >= 10 && k <= 15);
        end
    endtask

    task automatic test_night_ped();
        int pq [1:14] = '{1, 1, 1, 1, 1, 2, 2, 7, 7, 0, 6, 6, 6, 1};
        int e;
        start(1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            e = pq[k];
            checks++;
            if ({phase, walk, ped_ack} !== {3'(e), e == 6, k == 11}) begin
                failures++;
                $display("FAIL night_ped k=%0d phase=%0d walk=%b ack=%b want phase=%0d walk=%b ack=%b",
                         k, phase, walk, ped_ack, e, e == 6, k == 11);
            end
            night = (k == 7 || k == 8);
            ped_req = (k == 8);
        end
    endtask

    task automatic test_reset_midwalk();
        start(1'b1);
        @(negedge clock);
        checks++;
        if ({phase, walk, ped_ack} !== {3'd6, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL midwalk_enter phase=%0d walk=%b ack=%b want 6 1 1", phase, walk, ped_ack);
        end
        reset_n = 1'b0; night = 1'b1; ped_req = 1'b1;
        @(negedge clock);
        checks++;
        if ({phase, red, blue, green, walk, ped_ack} !== {3'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midwalk_reset phase=%0d red=%b blue=%b green=%b walk=%b ack=%b want 0 11 00 00 0 0",
                     phase, red, blue, green, walk, ped_ack);
        end
        reset_n = 1'b1; night = 1'b0; ped_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({phase, walk} !== {3'd1, 1'b0}) begin
            failures++;
            $display("FAIL midwalk_after phase=%0d walk=%b want 1 0", phase, walk);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_ped_pulse();
        test_ped_held();
        test_night();
        test_night_ped();
        test_reset_midwalk();
        inv_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
